// File: rtl/csrhpm.sv
// csrhpm: machine-mode HPM counters mhpmcounter3..31 with selectors mhpmevent3..31.
// Define HPM_OVERFLOW_EN for OF/MINH/SINH/UINH, RV32 event-high CSRs and LCOFIRequestM.
module csrhpm #(
  parameter int XLEN         = 64,
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CSRMWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  input  logic [NUM_EVENTS-1:0] EventsM,
  input  logic [1:0]            PrivilegeModeM,
  input  logic [31:0]           MCOUNTINHIBIT_REGW,
  output logic [XLEN-1:0]       CSRHPMReadValM,
  output logic                  IllegalCSRHPMAccessM,
  output logic                  HPMHitM,
  output logic                  LCOFIRequestM
);
  localparam bit RV32 = (XLEN == 32);
`ifdef HPM_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic [63:0]             cnt_q [NUM_COUNTERS];
  logic [7:0]              sel_q [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] of_q, minh_q, sinh_q, uinh_q;
  logic [NUM_COUNTERS-1:0] mode_inh, inc, wrap, cnt_wr;
  logic [63:0]             wd64, rd64;
  logic [255:0]            ev_ext;
  logic [4:0]              idx;
  logic                    in_rng, is_cnt_lo, is_cnt_hi, is_evt_lo, is_evt_hi, wr_ok;

  assign wd64   = 64'(CSRWriteValM);
  assign ev_ext = 256'(EventsM);

  // CSR index 3..31 lives in address bits [4:0]; bits [11:5] pick the range.
  assign in_rng    = CSRAdrM[4:0] >= 5'd3;
  assign idx       = CSRAdrM[4:0] - 5'd3;
  assign is_cnt_lo = in_rng && (CSRAdrM[11:5] == 7'h58);
  assign is_cnt_hi = in_rng && (CSRAdrM[11:5] == 7'h5C);
  assign is_evt_lo = in_rng && (CSRAdrM[11:5] == 7'h19);
  assign is_evt_hi = in_rng && (CSRAdrM[11:5] == 7'h39);

  assign HPMHitM              = is_cnt_lo | is_cnt_hi | is_evt_lo | is_evt_hi;
  assign IllegalCSRHPMAccessM = (is_cnt_hi && !RV32) || (is_evt_hi && !(RV32 && OVF));
  assign wr_ok                = CSRMWriteM && !IllegalCSRHPMAccessM;

  always_comb begin
    mode_inh = '0;
    inc      = '0;
    wrap     = '0;
    cnt_wr   = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      case (PrivilegeModeM)
        2'b11:   mode_inh[k] = minh_q[k];
        2'b01:   mode_inh[k] = sinh_q[k];
        2'b00:   mode_inh[k] = uinh_q[k];
        default: mode_inh[k] = 1'b0;
      endcase
      cnt_wr[k] = wr_ok && (is_cnt_lo || is_cnt_hi) && (int'(idx) == k);
      inc[k]    = (sel_q[k] != 8'd0) && (int'(sel_q[k]) < NUM_EVENTS) && ev_ext[sel_q[k]] &&
                  !MCOUNTINHIBIT_REGW[k+3] && !mode_inh[k];
      // A CSR write to the counter drops the increment, so it cannot wrap that cycle.
      wrap[k]   = inc[k] && !cnt_wr[k] && (&cnt_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        cnt_q[k] <= '0;
        sel_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (cnt_wr[k]) begin
          if (is_cnt_hi)  cnt_q[k][63:32] <= wd64[31:0];
          else if (RV32)  cnt_q[k][31:0]  <= wd64[31:0];
          else            cnt_q[k]        <= wd64;
        end else if (inc[k]) begin
          cnt_q[k] <= cnt_q[k] + 64'd1;
        end
        if (wr_ok && is_evt_lo && (int'(idx) == k)) sel_q[k] <= wd64[7:0];
      end
    end
  end

`ifdef HPM_OVERFLOW_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      of_q   <= '0;
      minh_q <= '0;
      sinh_q <= '0;
      uinh_q <= '0;
    end else begin
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (wr_ok && (int'(idx) == k) && ((is_evt_lo && !RV32) || is_evt_hi))
          {of_q[k], minh_q[k], sinh_q[k], uinh_q[k]} <= RV32 ? wd64[31:28] : wd64[63:60];
        // Wrap beats a same-cycle write of OF=0.
        if (wrap[k]) of_q[k] <= 1'b1;
      end
    end
  end
`else
  assign of_q   = '0;
  assign minh_q = '0;
  assign sinh_q = '0;
  assign uinh_q = '0;
`endif

  assign LCOFIRequestM = |of_q;

  always_comb begin
    rd64 = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if ((int'(idx) == k) && !IllegalCSRHPMAccessM) begin
        if (is_cnt_lo)      rd64 = RV32 ? {32'd0, cnt_q[k][31:0]} : cnt_q[k];
        else if (is_cnt_hi) rd64 = {32'd0, cnt_q[k][63:32]};
        else if (is_evt_lo) rd64 = RV32 ? {56'd0, sel_q[k]} :
                                   {of_q[k], minh_q[k], sinh_q[k], uinh_q[k], 52'd0, sel_q[k]};
        else if (is_evt_hi) rd64 = {32'd0, of_q[k], minh_q[k], sinh_q[k], uinh_q[k], 28'd0};
      end
    end
  end

  assign CSRHPMReadValM = rd64[XLEN-1:0];

  logic unused_sink;
  assign unused_sink = ^{MCOUNTINHIBIT_REGW, wd64, rd64, wrap, ev_ext};
endmodule

// File: tb/tb_csrhpm.sv
// tb_csrhpm: directed checks of csrhpm with an RV64 instance (a) and an RV32 instance (b).
module tb_csrhpm;
`ifdef HPM_OVERFLOW_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        we_a, we_b;
  logic [11:0] adr;
  logic [63:0] wdata;
  logic [15:0] ev;
  logic [1:0]  mode;
  logic [31:0] inh;
  logic [63:0] rd_a;
  logic [31:0] rd_b;
  logic        ill_a, ill_b, hit_a, hit_b, lcofi_a, lcofi_b;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  csrhpm #(.XLEN(64), .NUM_COUNTERS(4), .NUM_EVENTS(16)) u_a (
    .clk(clk), .reset(reset), .CSRMWriteM(we_a), .CSRAdrM(adr), .CSRWriteValM(wdata),
    .EventsM(ev), .PrivilegeModeM(mode), .MCOUNTINHIBIT_REGW(inh),
    .CSRHPMReadValM(rd_a), .IllegalCSRHPMAccessM(ill_a), .HPMHitM(hit_a),
    .LCOFIRequestM(lcofi_a));

  csrhpm #(.XLEN(32), .NUM_COUNTERS(4), .NUM_EVENTS(16)) u_b (
    .clk(clk), .reset(reset), .CSRMWriteM(we_b), .CSRAdrM(adr), .CSRWriteValM(wdata[31:0]),
    .EventsM(ev), .PrivilegeModeM(mode), .MCOUNTINHIBIT_REGW(inh),
    .CSRHPMReadValM(rd_b), .IllegalCSRHPMAccessM(ill_b), .HPMHitM(hit_b),
    .LCOFIRequestM(lcofi_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [11:0] a, input logic [63:0] d);
    adr = a; wdata = d; we_a = 1'b1;
    tick();
    we_a = 1'b0;
  endtask

  task automatic wr_b(input logic [11:0] a, input logic [63:0] d);
    adr = a; wdata = d; we_b = 1'b1;
    tick();
    we_b = 1'b0;
  endtask

  task automatic pulse(input logic [15:0] m, input int n);
    ev = m;
    repeat (n) tick();
    ev = '0;
  endtask

  task automatic rd_a_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    adr = a;
    #1;
    check(tag, rd_a, exp);
  endtask

  task automatic rd_b_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    adr = a;
    #1;
    check(tag, {32'd0, rd_b}, exp);
  endtask

  initial begin
    reset = 1'b0; we_a = 1'b0; we_b = 1'b0; adr = 12'h000; wdata = '0;
    ev = '0; mode = 2'b11; inh = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();

    rd_a_chk("rst_cnt", 12'hB03, 64'd0);
    rd_a_chk("rst_evt", 12'h323, 64'd0);
    check("rst_lcofi", {63'd0, lcofi_a}, 64'd0);
    adr = 12'hB03; #1;
    check("hit_b03", {63'd0, hit_a}, 64'd1);

    wr_a(12'h323, 64'd5);
    pulse(16'h0020, 10);
    rd_a_chk("count10", 12'hB03, 64'd10);

    inh = 32'h8;
    pulse(16'h0020, 5);
    rd_a_chk("inhibit", 12'hB03, 64'd10);
    inh = '0;

    wr_a(12'h323, 64'd20);
    pulse(16'hFFFF, 3);
    rd_a_chk("sel_oob", 12'hB03, 64'd10);

    wr_a(12'h323, 64'hFFFF_FFFF_FFFF_FF07);
    rd_a_chk("evt_fields", 12'h323, OVF ? 64'hF000_0000_0000_0007 : 64'h7);
    check("lcofi_of_wr", {63'd0, lcofi_a}, {63'd0, OVF});
    wr_a(12'h323, 64'd5);
    check("lcofi_clr", {63'd0, lcofi_a}, 64'd0);

    adr = 12'hB83; #1;
    check("ill_b83_a", {63'd0, ill_a}, 64'd1);
    check("hit_b83_a", {63'd0, hit_a}, 64'd1);
    wr_a(12'hB83, 64'h55);
    rd_a_chk("ill_nochg", 12'hB03, 64'd10);
    adr = 12'h723; #1;
    check("ill_723_a", {63'd0, ill_a}, 64'd1);
    wr_a(12'hB10, 64'h99);
    rd_a_chk("unimpl_rd", 12'hB10, 64'd0);
    check("unimpl_ill", {63'd0, ill_a}, 64'd0);
    check("unimpl_hit", {63'd0, hit_a}, 64'd1);
    adr = 12'hB00; #1;
    check("nohit_b00", {63'd0, hit_a}, 64'd0);

    wr_a(12'hB04, 64'h1234_5678_9ABC_DEF0);
    rd_a_chk("cnt1_wr", 12'hB04, 64'h1234_5678_9ABC_DEF0);

    ev = 16'h0020;
    repeat (2) tick();
    rd_a_chk("count12", 12'hB03, 64'd12);
    #2 reset = 1'b0;
    #1;
    check("async_rst", rd_a, 64'd0);
    rd_a_chk("async_rst1", 12'hB04, 64'd0);
    rd_a_chk("async_rsts", 12'h323, 64'd0);
    reset = 1'b1;
    ev = '0;
    tick();

    wr_b(12'h323, 64'd5);
    wr_b(12'hB03, 64'hFFFF_FFFF);
    pulse(16'h0020, 1);
    rd_b_chk("rv32_lo", 12'hB03, 64'd0);
    rd_b_chk("rv32_hi", 12'hB83, 64'd1);
    check("rv32_hi_ill", {63'd0, ill_b}, 64'd0);
    ev = 16'h0020;
    wr_b(12'hB03, 64'hAAAA_0000);
    ev = '0;
    rd_b_chk("rv32_wr_lo", 12'hB03, 64'hAAAA_0000);
    rd_b_chk("rv32_wr_hi", 12'hB83, 64'd1);
    wr_b(12'hB83, 64'h77);
    rd_b_chk("rv32_hwr_hi", 12'hB83, 64'h77);
    rd_b_chk("rv32_hwr_lo", 12'hB03, 64'hAAAA_0000);
    adr = 12'h723; #1;
    check("rv32_723_ill", {63'd0, ill_b}, {63'd0, !OVF});
    rd_b_chk("rv32_evt", 12'h323, 64'd5);

    wr_a(12'h323, 64'd5);
    wr_a(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    pulse(16'h0020, 1);
    rd_a_chk("wrap_cnt", 12'hB03, 64'd0);
    check("wrap_lcofi", {63'd0, lcofi_a}, {63'd0, OVF});
    rd_a_chk("wrap_of", 12'h323, OVF ? 64'h8000_0000_0000_0005 : 64'd5);
    wr_a(12'h323, 64'd5);
    check("of_clr_lcofi", {63'd0, lcofi_a}, 64'd0);

`ifdef HPM_OVERFLOW_EN
    wr_a(12'hB03, 64'hFFFF_FFFF_FFFF_FFFF);
    ev = 16'h0020;
    wr_a(12'h323, 64'd5);
    ev = '0;
    rd_a_chk("wrap_vs_wr", 12'h323, 64'h8000_0000_0000_0005);
    check("wrap_vs_wr_l", {63'd0, lcofi_a}, 64'd1);
    wr_a(12'h323, 64'h1000_0000_0000_0005);
    mode = 2'b00;
    pulse(16'h0020, 3);
    rd_a_chk("uinh_u", 12'hB03, 64'd0);
    mode = 2'b11;
    pulse(16'h0020, 2);
    rd_a_chk("uinh_m", 12'hB03, 64'd2);
`endif

    wr_b(12'h723, 64'h8000_0000);
    check("rv32_evh_l", {63'd0, lcofi_b}, {63'd0, OVF});
    rd_b_chk("rv32_evh_rd", 12'h723, OVF ? 64'h8000_0000 : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
